// File: rtl/sipo_pkg.sv
// ============================================================================
// Module   : sipo_pkg
// Brief    : Shared constants and parity helper for the SIPO frame collector.
// Revision : 1.0
// ============================================================================
`default_nettype none

package sipo_pkg;

  localparam int SIPO_DEFAULT_WIDTH = 8;
  localparam int CNT_W              = $clog2(SIPO_DEFAULT_WIDTH + 1);

  // Returns the bit that makes data plus parity contain an even number of ones.
  function automatic logic even_parity(input logic [31:0] data);
    return ^data;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sipo_frame_collector_if.sv
// ============================================================================
// Module   : sipo_frame_collector_if
// Brief    : Serial-in / parallel-out bus with a valid/ready word handshake.
//            The parity_err signal exists only with SIPO_PARITY_CHECK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface sipo_frame_collector_if
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_DEFAULT_WIDTH
);

  localparam int c_CNT_W = $clog2(WIDTH + 1);

  logic               en;
  logic               din;
  logic               clr;
  logic               dout_ready;
  logic [WIDTH-1:0]   dout;
  logic               dout_valid;
  logic               overrun;
  logic [c_CNT_W-1:0] bit_cnt;
`ifdef SIPO_PARITY_CHECK_EN
  logic               parity_err;
`endif

  modport master (
    output en, din, clr, dout_ready,
    input  dout, dout_valid, overrun, bit_cnt
`ifdef SIPO_PARITY_CHECK_EN
    , input parity_err
`endif
  );

  modport slave (
    input  en, din, clr, dout_ready,
    output dout, dout_valid, overrun, bit_cnt
`ifdef SIPO_PARITY_CHECK_EN
    , output parity_err
`endif
  );

endinterface

`default_nettype wire

// File: rtl/sipo_out_slot.sv
// ============================================================================
// Module   : sipo_out_slot
// Brief    : One-entry valid/ready holding register with sticky overrun flag.
//            Optional parity_err tag with SIPO_PARITY_CHECK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sipo_out_slot #(
  parameter int WIDTH = 8
) (
  input  wire logic             sys_clk,
  input  wire logic             sys_rst,
  input  wire logic             load,
  input  wire logic [WIDTH-1:0] load_data,
`ifdef SIPO_PARITY_CHECK_EN
  input  wire logic             load_perr,
  output logic                  parity_err,
`endif
  input  wire logic             dout_ready,
  input  wire logic             clr,
  output logic [WIDTH-1:0]      dout,
  output logic                  dout_valid,
  output logic                  overrun
);

  logic [WIDTH-1:0] r_dout;
  logic             r_valid;
  logic             r_overrun;
  logic             w_slot_free;
`ifdef SIPO_PARITY_CHECK_EN
  logic             r_perr;
`endif

  // A word draining this cycle frees the slot for a same-cycle load.
  assign w_slot_free = !r_valid || dout_ready;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_dout    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
      r_perr    <= 1'b0;
`endif
    end else begin
      if (load && w_slot_free) begin
        r_dout  <= load_data;
        r_valid <= 1'b1;
`ifdef SIPO_PARITY_CHECK_EN
        r_perr  <= load_perr;
`endif
      end else if (r_valid && dout_ready) begin
        r_valid <= 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
        r_perr  <= 1'b0;
`endif
      end

      if (clr) begin
        r_overrun <= 1'b0;
      end else if (load && !w_slot_free) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign overrun    = r_overrun;
`ifdef SIPO_PARITY_CHECK_EN
  assign parity_err = r_perr;
`endif

endmodule

`default_nettype wire

// File: rtl/sipo_frame_collector.sv
// ============================================================================
// Module   : sipo_frame_collector
// Brief    : Assembles WIDTH-bit words from an enabled serial bit stream.
//            Define SIPO_PARITY_CHECK_EN for an extra even-parity bit per frame.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sipo_frame_collector
  import sipo_pkg::*;
#(
  parameter int WIDTH     = SIPO_DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input wire logic             sys_clk,
  input wire logic             sys_rst,
  sipo_frame_collector_if.slave bus
);

  localparam int c_CNT_W = $clog2(WIDTH + 1);
`ifdef SIPO_PARITY_CHECK_EN
  localparam int c_LAST_BIT = WIDTH;
`else
  localparam int c_LAST_BIT = WIDTH - 1;
`endif

  logic [WIDTH-1:0]   r_shift;
  logic [c_CNT_W-1:0] r_bit_cnt;
  logic [WIDTH-1:0]   w_shift_next;
  logic [WIDTH-1:0]   w_load_data;
  logic               w_take;
  logic               w_complete;
  logic               w_shift_en;

  assign w_take     = bus.en && !bus.clr;
  assign w_complete = w_take && (r_bit_cnt == c_CNT_W'(c_LAST_BIT));

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shift_next = {r_shift[WIDTH-2:0], bus.din};
    end else begin : g_lsb_first
      assign w_shift_next = {bus.din, r_shift[WIDTH-1:1]};
    end
  endgenerate

`ifdef SIPO_PARITY_CHECK_EN
  logic w_load_perr;
  // The trailing parity bit is checked against the stored word, never shifted in.
  assign w_shift_en  = w_take && !w_complete;
  assign w_load_data = r_shift;
  assign w_load_perr = even_parity(32'(r_shift)) != bus.din;
`else
  assign w_shift_en  = w_take;
  assign w_load_data = w_shift_next;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (bus.clr) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else begin
      if (w_take) begin
        r_bit_cnt <= w_complete ? '0 : r_bit_cnt + 1'b1;
      end
      if (w_shift_en) begin
        r_shift <= w_shift_next;
      end
    end
  end

  assign bus.bit_cnt = r_bit_cnt;

  sipo_out_slot #(
    .WIDTH      (WIDTH)
  ) u_out_slot (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .load       (w_complete),
    .load_data  (w_load_data),
`ifdef SIPO_PARITY_CHECK_EN
    .load_perr  (w_load_perr),
    .parity_err (bus.parity_err),
`endif
    .dout_ready (bus.dout_ready),
    .clr        (bus.clr),
    .dout       (bus.dout),
    .dout_valid (bus.dout_valid),
    .overrun    (bus.overrun)
  );

endmodule

`default_nettype wire

// File: tb/tb_sipo_frame_collector.sv
// ============================================================================
// Module   : tb_sipo_frame_collector
// Brief    : Drives an MSB-first and an LSB-first collector with one bit stream
//            and compares both against a frame-level reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sipo_frame_collector;
  import sipo_pkg::*;

  localparam int W = 8;
`ifdef SIPO_PARITY_CHECK_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic en = 1'b0, din = 1'b0, clr = 1'b0, ready = 1'b0;

  always #5 sys_clk = ~sys_clk;

  sipo_frame_collector_if #(.WIDTH(W)) bus_m ();
  sipo_frame_collector_if #(.WIDTH(W)) bus_l ();

  assign bus_m.en = en;  assign bus_m.din = din;  assign bus_m.clr = clr;  assign bus_m.dout_ready = ready;
  assign bus_l.en = en;  assign bus_l.din = din;  assign bus_l.clr = clr;  assign bus_l.dout_ready = ready;

  sipo_frame_collector #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .sys_clk (sys_clk), .sys_rst (sys_rst), .bus (bus_m.slave));
  sipo_frame_collector #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .sys_clk (sys_clk), .sys_rst (sys_rst), .bus (bus_l.slave));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: bits of the partial frame as a list, plus the output slot.
  bit           m_bits[$];
  logic [W-1:0] m_dout_m = '0, m_dout_l = '0;
  bit           m_valid = 0, m_ovr = 0, m_perr = 0;

  task automatic model_edge();
    bit           done = 0;
    logic [W-1:0] wm = '0, wl = '0;
    bit           pe = 0;
    if (sys_rst) begin
      m_bits.delete();
      m_dout_m = '0; m_dout_l = '0; m_valid = 0; m_ovr = 0; m_perr = 0;
    end else begin
      if (clr) begin
        m_bits.delete();
        m_ovr = 0;
      end else if (en) begin
        m_bits.push_back(din);
        if (m_bits.size() == FRAME) begin
          for (int i = 0; i < W; i++) begin
            wm[W-1-i] = m_bits[i];
            wl[i]     = m_bits[i];
          end
`ifdef SIPO_PARITY_CHECK_EN
          pe = ((^wm) != m_bits[W]);
`endif
          done = 1;
          m_bits.delete();
        end
      end
      if (done && (!m_valid || ready)) begin
        m_dout_m = wm; m_dout_l = wl; m_valid = 1; m_perr = pe;
      end else if (done) begin
        m_ovr = 1;
      end else if (m_valid && ready) begin
        m_valid = 0; m_perr = 0;
      end
    end
  endtask

  task automatic check_all();
    check_eq("m_dout",    bus_m.dout,       m_dout_m);
    check_eq("l_dout",    bus_l.dout,       m_dout_l);
    check_eq("m_valid",   bus_m.dout_valid, m_valid);
    check_eq("l_valid",   bus_l.dout_valid, m_valid);
    check_eq("m_overrun", bus_m.overrun,    m_ovr);
    check_eq("l_overrun", bus_l.overrun,    m_ovr);
    check_eq("m_bit_cnt", bus_m.bit_cnt,    m_bits.size());
    check_eq("l_bit_cnt", bus_l.bit_cnt,    m_bits.size());
`ifdef SIPO_PARITY_CHECK_EN
    check_eq("m_perr",    bus_m.parity_err, m_perr);
    check_eq("l_perr",    bus_l.parity_err, m_perr);
`endif
  endtask

  task automatic step();
    @(posedge sys_clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send_bit(input bit b);
    en = 1'b1; din = b;
    step();
    en = 1'b0; din = 1'b0;
  endtask

  // Sends frame positions first..last of word w (MSB of w first, good parity last).
  task automatic send_range(input logic [W-1:0] w, input int first, input int last, input bit ready_on_last);
    bit fb[FRAME];
    for (int i = 0; i < W; i++) fb[i] = w[W-1-i];
`ifdef SIPO_PARITY_CHECK_EN
    fb[W] = ^w;
`endif
    for (int i = first; i <= last; i++) begin
      if (ready_on_last && i == FRAME - 1) ready = 1'b1;
      send_bit(fb[i]);
    end
  endtask

  task automatic send_frame(input logic [W-1:0] w, input bit ready_on_last);
    send_range(w, 0, FRAME - 1, ready_on_last);
  endtask

  initial begin
    idle(2);
    check_eq("rst_dout",  bus_m.dout,       0);
    check_eq("rst_valid", bus_m.dout_valid, 0);
    check_eq("rst_cnt",   bus_m.bit_cnt,    0);
    sys_rst = 1'b0;

    ready = 1'b1;
    send_frame(8'hB2, 1'b0);
    check_eq("b2_msb",   bus_m.dout,       8'hB2);
    check_eq("b2_lsb",   bus_l.dout,       8'h4D);
    check_eq("b2_valid", bus_m.dout_valid, 1);
    check_eq("b2_cnt",   bus_m.bit_cnt,    0);
    idle(1);
    check_eq("b2_onecyc", bus_m.dout_valid, 0);

    ready = 1'b0;
    send_frame(8'hA5, 1'b0);
    send_frame(8'h3C, 1'b0);
    check_eq("ovr_dout",  bus_m.dout,       8'hA5);
    check_eq("ovr_valid", bus_m.dout_valid, 1);
    check_eq("ovr_flag",  bus_m.overrun,    1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_eq("clr_ovr",  bus_m.overrun, 0);
    check_eq("clr_dout", bus_m.dout,    8'hA5);

    send_frame(8'h0F, 1'b1);
    check_eq("b2b_valid", bus_m.dout_valid, 1);
    check_eq("b2b_dout",  bus_m.dout,       8'h0F);
    check_eq("b2b_lsb",   bus_l.dout,       8'hF0);
    check_eq("b2b_ovr",   bus_m.overrun,    0);
    idle(1);

    send_range(8'h96, 0, 3, 1'b0);
    repeat (3) begin
      step();
      check_eq("gap_cnt", bus_m.bit_cnt, 4);
    end
    send_range(8'h96, 4, FRAME - 1, 1'b0);
    check_eq("gap_dout", bus_m.dout, 8'h96);

    send_range(8'hFF, 0, 4, 1'b0);
    check_eq("pre_clr_cnt", bus_m.bit_cnt, 5);
    clr = 1'b1; en = 1'b1; din = 1'b1;
    step();
    clr = 1'b0; en = 1'b0; din = 1'b0;
    check_eq("abort_cnt", bus_m.bit_cnt, 0);
    send_frame(8'h5A, 1'b0);
    check_eq("abort_dout", bus_m.dout, 8'h5A);

    ready = 1'b0;
    idle(1);
    send_frame(8'hC3, 1'b0);
    send_range(8'h00, 0, 2, 1'b0);
    check_eq("prerst_cnt",   bus_m.bit_cnt,    3);
    check_eq("prerst_valid", bus_m.dout_valid, 1);
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    check_eq("midrst_dout",  bus_m.dout,       0);
    check_eq("midrst_valid", bus_m.dout_valid, 0);
    check_eq("midrst_ovr",   bus_m.overrun,    0);
    check_eq("midrst_cnt",   bus_m.bit_cnt,    0);

`ifdef SIPO_PARITY_CHECK_EN
    ready = 1'b1;
    send_range(8'h81, 0, W - 1, 1'b0);
    send_bit(1'b1);
    check_eq("par_bad_dout", bus_m.dout,       8'h81);
    check_eq("par_bad_err",  bus_m.parity_err, 1);
    idle(1);
    check_eq("par_clear",    bus_m.parity_err, 0);
    send_range(8'h81, 0, W - 1, 1'b0);
    send_bit(1'b0);
    check_eq("par_ok_dout",  bus_m.dout,       8'h81);
    check_eq("par_ok_err",   bus_m.parity_err, 0);
`endif

    repeat (3000) begin
      sys_rst = ($urandom_range(0, 199) == 0);
      clr     = ($urandom_range(0, 31) == 0);
      en      = $urandom_range(0, 1) == 1;
      din     = $urandom_range(0, 1) == 1;
      ready   = ($urandom_range(0, 3) != 0);
      step();
    end
    sys_rst = 1'b0; clr = 1'b0; en = 1'b0; ready = 1'b1;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
